uart_rx_axis_fifo: RTL

//  Receive-side counterpart of the AXIS->FIFO->UART TX path.

---
 rtl/uart_rx_axis_fifo.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_axis_fifo.sv
// 8N1 UART receiver feeding a first-word-fall-through FIFO exposed as an AXI-Stream master.
// A one-byte staging register holds the newest byte so tlast can be attached on line-idle timeout.
module uart_rx_axis_fifo #(
  parameter int unsigned CLK_FREQ  = 100000000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned IDLE_BITS = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx,
  output logic [DATA_BITS-1:0]     m_axis_data,
  output logic                     m_axis_valid,
  input  logic                     m_axis_ready,
  output logic                     m_axis_last,
  output logic                     frame_err,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned IDLE_CLKS    = IDLE_BITS * CLKS_PER_BIT;
  localparam int unsigned CW           = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned BW           = $clog2(DATA_BITS + 1);
  localparam int unsigned IW           = $clog2(IDLE_CLKS + 1);
  localparam int unsigned AW           = $clog2(DEPTH);
  localparam int unsigned NW           = AW + 1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // Synchroniser; prime_q marks when rx_sync_q reflects the real pin rather than its preset.
  logic       rx_meta_q, rx_sync_q;
  logic [1:0] prime_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      prime_q   <= 2'b00;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      prime_q   <= {prime_q[0], 1'b1};
    end
  end

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic [BW-1:0]        bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 armed_q;
  logic                 byte_valid_q;
  logic                 frame_err_q;
  logic                 start_edge;

  assign start_edge = (state_q == StIdle) && armed_q && !rx_sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      armed_q      <= 1'b0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_edge) begin
            state_q <= StStart;
            cnt_q   <= '0;
            armed_q <= 1'b0;
          end else if (prime_q[1] && rx_sync_q) begin
            armed_q <= 1'b1;
          end
        end
        StStart: begin
          if (cnt_q == CW'(HALF_BIT - 1)) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= rx_sync_q ? StIdle : StData;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StData: begin
          if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
            cnt_q   <= '0;
            shift_q <= DATA_BITS'({rx_sync_q, shift_q} >> 1);
            if (bit_q == BW'(DATA_BITS - 1)) state_q <= StStop;
            else                             bit_q   <= bit_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StStop: begin
          if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
            cnt_q   <= '0;
            state_q <= StIdle;
            if (rx_sync_q) byte_valid_q <= 1'b1;
            else           frame_err_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Staging register: the newest byte waits here until either another byte
  // arrives (pushed with last=0) or the line stays idle long enough (last=1).
  logic                 stage_full_q;
  logic [DATA_BITS-1:0] stage_q;
  logic [IW-1:0]        idle_cnt_q;
  logic                 idle_run, idle_hit;
  logic                 push, push_last;

  assign idle_run = (state_q == StIdle) && stage_full_q && !start_edge;
  assign idle_hit = idle_run && (idle_cnt_q == IW'(IDLE_CLKS - 1));

  always_comb begin
    push      = 1'b0;
    push_last = 1'b0;
    if (byte_valid_q) begin
      push = stage_full_q;
    end else if (idle_hit) begin
      push      = 1'b1;
      push_last = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_full_q <= 1'b0;
      stage_q      <= '0;
      idle_cnt_q   <= '0;
    end else if (byte_valid_q) begin
      stage_q      <= shift_q;
      stage_full_q <= 1'b1;
      idle_cnt_q   <= '0;
    end else if (idle_hit) begin
      stage_full_q <= 1'b0;
      idle_cnt_q   <= '0;
    end else if (idle_run) begin
      idle_cnt_q <= idle_cnt_q + 1'b1;
    end else begin
      idle_cnt_q <= '0;
    end
  end

  logic [DATA_BITS:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [NW-1:0]      count_q, count_d;
  logic               overflow_q;
  logic               pop, push_ok, full;

  assign full    = (count_q == NW'(DEPTH));
  assign pop     = m_axis_valid && m_axis_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok = push && (!full || pop);

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= push && !push_ok;
      count_q    <= count_d;
      if (push_ok) begin
        mem_q[wr_ptr_q] <= {push_last, stage_q};
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign m_axis_valid = (count_q != '0);
  assign m_axis_data  = mem_q[rd_ptr_q][DATA_BITS-1:0];
  assign m_axis_last  = mem_q[rd_ptr_q][DATA_BITS];
  assign frame_err    = frame_err_q;
  assign overflow     = overflow_q;
  assign fifo_count   = count_q;

endmodule
